alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter XLEN, default 32, SHALL set operand/result data width.
REQ-002 Parameter RA_W, default 5, SHALL set register address width; register 0 reads as zero.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 flush  in  1  discard all buffered entries.
REQ-006 in_valid / in_ready  in / out  1 / 1  decoded-instruction handshake.
REQ-007 in_op  in  4  ALU opcode; in_rs1, in_rs2, in_rd  in  RA_W  source and destination registers.
REQ-008 in_use_imm  in  1  select in_imm for operand B; in_imm  in  XLEN  immediate.
REQ-009 rf_raddr1, rf_raddr2  out  RA_W  register-file read addresses, combinational from in_rs1/in_rs2.
REQ-010 rf_rdata1, rf_rdata2  in  XLEN  same-cycle register-file read data.
REQ-011 wb_en  in  1, wb_rd  in  RA_W, wb_data  in  XLEN  writeback bypass bus.
REQ-012 out_valid / out_ready  out / in  1 / 1  handshake to ALU stage.
REQ-013 out_op  out  4, out_a, out_b  out  XLEN, out_rd  out  RA_W, out_illegal  out  1  head-entry contents.

Function
REQ-014 Block SHALL be a 2-entry in-order buffer with states EMPTY, ONE, FULL.
REQ-015 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL be a registered signal, high in EMPTY and ONE, low in FULL.
REQ-017 Transitions: accept-only increments, pop-only decrements, accept+pop keeps state; flush forces EMPTY next cycle regardless of other events.
REQ-018 out_valid SHALL be high in ONE and FULL; out_* SHALL show the oldest entry.
REQ-019 Latency: instruction accepted in cycle N SHALL appear on out_* with out_valid in cycle N+1 if buffer was empty; sustained throughput one per cycle.
REQ-020 Operand A capture: rs1==0 -> 0; else wb_en && wb_rd==rs1 -> wb_data; else rf_rdata1.
REQ-021 Operand B capture: in_use_imm -> in_imm; else same priority as REQ-020 on rs2.
REQ-022 Buffered entries SHALL snoop writeback: each cycle, a non-immediate, non-zero source of a held entry matching wb_rd with wb_en SHALL be replaced by wb_data.
REQ-023 out_illegal SHALL be set at capture when in_op is not one of AND, OR, ADD, SUB, EQ; entry still flows.
REQ-024 Simultaneous flush and accept: input SHALL be dropped; simultaneous flush and pop: pop completes, nothing remains.
REQ-025 out_* SHALL hold stable while out_valid && !out_ready.

Reset
REQ-026 Reset SHALL force EMPTY, in_ready=1, out_valid=0, out_op/out_a/out_b/out_rd/out_illegal=0.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously).
REQ-028 First accept SHALL be possible in the first rising edge after reset deassertion.

Structure
REQ-029 ALU opcode constants (AND, OR, ADD, SUB, EQ) and an entry struct (op, a, b, rd, rs1, rs2, use_imm, illegal) SHALL live in shared package core_pkg, used by this block and alu.
REQ-030 Operand-select logic of REQ-020/021 SHALL be one sub-module, operand_bypass, instantiated twice.

Verification
REQ-031 Reset then ADD rs1=1 (rf=5), rs2=2 (rf=7), rd=3, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, out_rd=3, out_illegal=0.
REQ-032 out_ready=0, three back-to-back in_valid -> two accepted, in_ready low after second, third held; release out_ready -> entries emerge in order, third accepted.
REQ-033 Accept SUB rs1=4 while wb_en=1, wb_rd=4, wb_data=0x1234, rf_rdata1=0 -> out_a=0x1234.
REQ-034 Entry held (out_ready=0) with rs2=6, then wb_en writes r6=0xAA -> out_b becomes 0xAA next cycle; rs1=0 with wb_rd=0 -> out_a stays 0.
REQ-035 FULL buffer, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emerges.
REQ-036 in_op=4'hF with in_use_imm=1, in_imm=0x10 -> out_illegal=1, out_b=0x10; reset asserted while FULL -> out_valid drops without clock edge.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared ALU opcode constants, issue-entry type and opcode check.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Datapath widths baked into entry_t; alu_issue parameters must match them.
    localparam int c_xlen = 32;
    localparam int c_ra_w = 5;

    localparam logic [3:0] c_op_and = 4'd0;
    localparam logic [3:0] c_op_or  = 4'd1;
    localparam logic [3:0] c_op_add = 4'd2;
    localparam logic [3:0] c_op_sub = 4'd3;
    localparam logic [3:0] c_op_eq  = 4'd4;

    typedef struct packed {
        logic [3:0]        op;
        logic [c_xlen-1:0] a;
        logic [c_xlen-1:0] b;
        logic [c_ra_w-1:0] rd;
        logic [c_ra_w-1:0] rs1;
        logic [c_ra_w-1:0] rs2;
        logic              use_imm;
        logic              illegal;
    } entry_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == c_op_and) || (op == c_op_or) || (op == c_op_add) ||
               (op == c_op_sub) || (op == c_op_eq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_if
// Description : Decode-in, register-file, writeback and ALU-out bus of alu_issue.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [RA_W-1:0] in_rs1;
    logic [RA_W-1:0] in_rs2;
    logic [RA_W-1:0] in_rd;
    logic            in_use_imm;
    logic [XLEN-1:0] in_imm;

    logic [RA_W-1:0] rf_raddr1;
    logic [RA_W-1:0] rf_raddr2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;

    logic            wb_en;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_op;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [RA_W-1:0] out_rd;
    logic            out_illegal;

    // Environment side: decoder, register file, writeback and ALU.
    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
        output rf_rdata1, rf_rdata2,
        output wb_en, wb_rd, wb_data,
        output out_ready,
        input  in_ready, rf_raddr1, rf_raddr2,
        input  out_valid, out_op, out_a, out_b, out_rd, out_illegal
    );

    // Issue-buffer side.
    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
        input  rf_rdata1, rf_rdata2,
        input  wb_en, wb_rd, wb_data,
        input  out_ready,
        output in_ready, rf_raddr1, rf_raddr2,
        output out_valid, out_op, out_a, out_b, out_rd, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
// Module      : operand_bypass
// Description : Operand select: immediate, hard-wired zero, writeback bypass, RF.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  wire logic            i_use_imm,
    input  wire logic [XLEN-1:0] i_imm,
    input  wire logic [RA_W-1:0] i_rs,
    input  wire logic [XLEN-1:0] i_rf_rdata,
    input  wire logic            i_wb_en,
    input  wire logic [RA_W-1:0] i_wb_rd,
    input  wire logic [XLEN-1:0] i_wb_data,
    output logic      [XLEN-1:0] o_operand
);

    always_comb begin
        if (i_use_imm) begin
            o_operand = i_imm;
        end else if (i_rs == '0) begin
            o_operand = '0;
        end else if (i_wb_en && (i_wb_rd == i_rs)) begin
            o_operand = i_wb_data;
        end else begin
            o_operand = i_rf_rdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Two-entry in-order ALU issue buffer with writeback snooping.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import core_pkg::*;
#(
    parameter int XLEN = c_xlen,
    parameter int RA_W = c_ra_w
) (
    input  wire logic  clk,
    input  wire logic  reset,
    input  wire logic  flush,
    alu_issue_if.slave bus
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            r_in_ready;
    entry_t          r_slot  [2];
    entry_t          w_snoop [2];
    entry_t          w_new;
    logic            w_accept;
    logic            w_pop;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;

    assign bus.rf_raddr1 = bus.in_rs1;
    assign bus.rf_raddr2 = bus.in_rs2;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != c_st_empty);
    assign w_accept      = bus.in_valid && r_in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    operand_bypass #(.XLEN(XLEN), .RA_W(RA_W)) u_bypass_a (
        .i_use_imm  (1'b0),
        .i_imm      ('0),
        .i_rs       (bus.in_rs1),
        .i_rf_rdata (bus.rf_rdata1),
        .i_wb_en    (bus.wb_en),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_data),
        .o_operand  (w_op_a)
    );

    operand_bypass #(.XLEN(XLEN), .RA_W(RA_W)) u_bypass_b (
        .i_use_imm  (bus.in_use_imm),
        .i_imm      (bus.in_imm),
        .i_rs       (bus.in_rs2),
        .i_rf_rdata (bus.rf_rdata2),
        .i_wb_en    (bus.wb_en),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_data),
        .o_operand  (w_op_b)
    );

    always_comb begin
        w_new         = '0;
        w_new.op      = bus.in_op;
        w_new.a       = w_op_a;
        w_new.b       = w_op_b;
        w_new.rd      = bus.in_rd;
        w_new.rs1     = bus.in_rs1;
        w_new.rs2     = bus.in_rs2;
        w_new.use_imm = bus.in_use_imm;
        w_new.illegal = !is_legal_op(bus.in_op);
    end

    // Held operands track in-flight writebacks so they never go stale.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_snoop[i] = r_slot[i];
            if (bus.wb_en && (r_slot[i].rs1 != '0) && (bus.wb_rd == r_slot[i].rs1)) begin
                w_snoop[i].a = bus.wb_data;
            end
            if (bus.wb_en && !r_slot[i].use_imm && (r_slot[i].rs2 != '0) &&
                (bus.wb_rd == r_slot[i].rs2)) begin
                w_snoop[i].b = bus.wb_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_empty: begin
                if (w_accept) w_state_next = c_st_one;
            end
            c_st_one: begin
                if (w_accept && !w_pop)      w_state_next = c_st_full;
                else if (!w_accept && w_pop) w_state_next = c_st_empty;
            end
            c_st_full: begin
                // in_ready is low here, so only a pop can move the state.
                if (w_pop) w_state_next = c_st_one;
            end
            default: w_state_next = c_st_empty;
        endcase
        if (flush) w_state_next = c_st_empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_empty;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != c_st_full);
        end
    end

    // Slot 0 is always the head; a pop shifts slot 1 down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
        end else begin
            r_slot[0] <= w_snoop[0];
            r_slot[1] <= w_snoop[1];
            if (!flush) begin
                if (w_pop) begin
                    r_slot[0] <= w_snoop[1];
                    if (w_accept) r_slot[0] <= w_new;
                end else if (w_accept) begin
                    if (r_state == c_st_empty) r_slot[0] <= w_new;
                    else                       r_slot[1] <= w_new;
                end
            end
        end
    end

    assign bus.out_op      = r_slot[0].op;
    assign bus.out_a       = r_slot[0].a;
    assign bus.out_b       = r_slot[0].b;
    assign bus.out_rd      = r_slot[0].rd;
    assign bus.out_illegal = r_slot[0].illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Directed and random checks of alu_issue against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;
    import core_pkg::*;

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_imm;
        logic [31:0] imm;
        logic        out_ready;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } stim_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [31:0] imm;
    } exp_entry_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] r0_junk;
    logic [31:0] rf [32];
    exp_entry_t  q [$];
    int          checks;
    int          failures;

    alu_issue_if #(.XLEN(32), .RA_W(5)) bus ();

    alu_issue #(.XLEN(32), .RA_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // Register 0 returns junk so the DUT's hard-wired zero is exercised.
    assign bus.rf_rdata1 = (bus.rf_raddr1 == 5'd0) ? r0_junk : rf[bus.rf_raddr1];
    assign bus.rf_rdata2 = (bus.rf_raddr2 == 5'd0) ? r0_junk : rf[bus.rf_raddr2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // An entry's operand is always the newest architectural value of its source.
    function automatic logic [31:0] src_val(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : rf[r];
    endfunction

    function automatic logic legal(input logic [3:0] op);
        return op inside {c_op_and, c_op_or, c_op_add, c_op_sub, c_op_eq};
    endfunction

    task automatic compare_model();
        check_eq("in_ready", bus.in_ready, q.size() < 2);
        check_eq("out_valid", bus.out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check_eq("out_op", bus.out_op, q[0].op);
            check_eq("out_a", bus.out_a, src_val(q[0].rs1));
            check_eq("out_b", bus.out_b, q[0].use_imm ? q[0].imm : src_val(q[0].rs2));
            check_eq("out_rd", bus.out_rd, q[0].rd);
            check_eq("out_illegal", bus.out_illegal, !legal(q[0].op));
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s           = '0;
        s.out_ready = 1'b1;
        return s;
    endfunction

    // Called at a falling edge; drives one cycle, advances the model, re-checks.
    task automatic step(input stim_t s);
        logic acc;
        logic pop;
        exp_entry_t e;
        bus.in_valid   = s.v;
        bus.in_op      = s.op;
        bus.in_rs1     = s.rs1;
        bus.in_rs2     = s.rs2;
        bus.in_rd      = s.rd;
        bus.in_use_imm = s.use_imm;
        bus.in_imm     = s.imm;
        bus.out_ready  = s.out_ready;
        bus.wb_en      = s.wb_en;
        bus.wb_rd      = s.wb_rd;
        bus.wb_data    = s.wb_data;
        flush          = s.flush;
        r0_junk        = $urandom;
        acc = s.v && (q.size() < 2);
        pop = s.out_ready && (q.size() > 0);
        e   = '{op: s.op, rd: s.rd, rs1: s.rs1, rs2: s.rs2, use_imm: s.use_imm, imm: s.imm};
        @(posedge clk);
        #1;
        if (s.flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (s.wb_en && (s.wb_rd != 5'd0)) rf[s.wb_rd] = s.wb_data;
        @(negedge clk);
        compare_model();
    endtask

    task automatic async_reset_check();
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        bus.wb_en    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_valid", bus.out_valid, 1'b0);
        check_eq("async_rst_ready", bus.in_ready, 1'b1);
        check_eq("async_rst_a", bus.out_a, 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        compare_model();
    endtask

    task automatic fill_full(input logic [4:0] rd_base);
        stim_t s;
        for (int k = 0; k < 2; k++) begin
            s           = idle_stim();
            s.out_ready = 1'b0;
            s.v         = 1'b1;
            s.op        = c_op_or;
            s.rs1       = 5'd1 + 5'(k);
            s.rs2       = 5'd2;
            s.rd        = rd_base + 5'(k);
            step(s);
        end
    endtask

    initial begin
        stim_t      s;
        logic [3:0] legal_ops [5];
        checks   = 0;
        failures = 0;
        legal_ops = '{c_op_and, c_op_or, c_op_add, c_op_sub, c_op_eq};
        for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : $urandom;
        reset   = 1'b1;
        flush   = 1'b0;
        r0_junk = 32'hDEAD_BEEF;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_rd = '0; bus.in_use_imm = 1'b0; bus.in_imm = '0;
        bus.out_ready = 1'b0; bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        repeat (2) @(negedge clk);

        check_eq("rst_valid", bus.out_valid, 1'b0);
        check_eq("rst_ready", bus.in_ready, 1'b1);
        check_eq("rst_op", bus.out_op, 4'd0);
        check_eq("rst_a", bus.out_a, 32'd0);
        check_eq("rst_b", bus.out_b, 32'd0);
        check_eq("rst_rd", bus.out_rd, 5'd0);
        check_eq("rst_illegal", bus.out_illegal, 1'b0);
        reset = 1'b0;

        // Basic ADD accepted on the first edge after reset.
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        s = idle_stim();
        s.v = 1'b1; s.op = c_op_add; s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3;
        step(s);
        check_eq("add_valid", bus.out_valid, 1'b1);
        check_eq("add_a", bus.out_a, 32'd5);
        check_eq("add_b", bus.out_b, 32'd7);
        check_eq("add_rd", bus.out_rd, 5'd3);
        check_eq("add_illegal", bus.out_illegal, 1'b0);
        step(idle_stim());

        // Back-to-back under stall, then release.
        for (int k = 0; k < 3; k++) begin
            s = idle_stim();
            s.out_ready = 1'b0; s.v = 1'b1; s.op = c_op_and;
            s.rs1 = 5'd7; s.rs2 = 5'd8; s.rd = 5'd10 + 5'(k);
            step(s);
        end
        check_eq("stall_ready_low", bus.in_ready, 1'b0);
        check_eq("stall_head_rd", bus.out_rd, 5'd10);
        for (int k = 0; k < 5; k++) begin
            s = idle_stim();
            s.v = (q.size() < 2) && (k < 2); s.op = c_op_and;
            s.rs1 = 5'd7; s.rs2 = 5'd8; s.rd = 5'd12;
            step(s);
        end

        // Capture-time writeback bypass.
        rf[4] = 32'd0;
        s = idle_stim();
        s.v = 1'b1; s.op = c_op_sub; s.rs1 = 5'd4; s.rs2 = 5'd5; s.rd = 5'd9;
        s.wb_en = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'h1234;
        step(s);
        check_eq("bypass_a", bus.out_a, 32'h1234);
        step(idle_stim());

        // Snoop into a held entry; register 0 never snoops.
        s = idle_stim();
        s.out_ready = 1'b0; s.v = 1'b1; s.op = c_op_eq; s.rs1 = 5'd0; s.rs2 = 5'd6; s.rd = 5'd1;
        step(s);
        s = idle_stim();
        s.out_ready = 1'b0; s.wb_en = 1'b1; s.wb_rd = 5'd6; s.wb_data = 32'hAA;
        step(s);
        check_eq("snoop_b", bus.out_b, 32'hAA);
        s.wb_rd = 5'd0; s.wb_data = 32'h55;
        step(s);
        check_eq("snoop_r0_a", bus.out_a, 32'd0);
        step(idle_stim());

        // Flush with a simultaneous input drops everything.
        fill_full(5'd20);
        s = idle_stim();
        s.out_ready = 1'b0; s.flush = 1'b1; s.v = 1'b1; s.op = c_op_add; s.rd = 5'd25;
        step(s);
        check_eq("flush_valid", bus.out_valid, 1'b0);
        check_eq("flush_ready", bus.in_ready, 1'b1);
        step(idle_stim());
        check_eq("flush_nothing", bus.out_valid, 1'b0);

        // Illegal opcode still flows with its immediate.
        s = idle_stim();
        s.v = 1'b1; s.op = 4'hF; s.use_imm = 1'b1; s.imm = 32'h10; s.rs2 = 5'd3;
        step(s);
        check_eq("illegal_flag", bus.out_illegal, 1'b1);
        check_eq("illegal_b", bus.out_b, 32'h10);
        step(idle_stim());

        fill_full(5'd28);
        check_eq("full_before_rst", bus.out_valid, 1'b1);
        async_reset_check();

        for (int i = 0; i < 600; i++) begin
            s.v         = ($urandom_range(0, 3) != 0);
            s.op        = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                                                      : legal_ops[$urandom_range(0, 4)];
            s.rs1       = 5'($urandom_range(0, 7));
            s.rs2       = 5'($urandom_range(0, 7));
            s.rd        = 5'($urandom);
            s.use_imm   = ($urandom_range(0, 3) == 0);
            s.imm       = $urandom;
            s.out_ready = 1'($urandom_range(0, 1));
            s.flush     = ($urandom_range(0, 15) == 0);
            s.wb_en     = 1'($urandom_range(0, 1));
            s.wb_rd     = 5'($urandom_range(0, 7));
            s.wb_data   = $urandom;
            step(s);
            if (i == 300) async_reset_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
